// File: rtl/lianliankan_pkg.sv
// Shared grid constants and controller state/result types for the
// card-matching game.
package lianliankan_pkg;

    localparam int ROWS   = 6;
    localparam int COLS   = 6;
    localparam int N      = ROWS * COLS;
    localparam int FACE_W = 4;

    // Controller phases: picking two cards, then resolving the pair.
    typedef enum logic [2:0] {
        IDLE,
        ONE,
        WAIT,
        CMP,
        HOLD,
        RES_A,
        RES_B,
        DONE
    } state_t;

    typedef enum logic {
        MATCH,
        MISMATCH
    } result_t;

endpackage

// File: rtl/match_ctrl_cursor_nav.sv
// Cursor navigation: row/column registers with per-axis wrap, fixed move
// priority (up > dn > lt > rt), and linear index / one-hot decode.
module cursor_nav
    import lianliankan_pkg::*;
#(
    parameter int ROWS  = lianliankan_pkg::ROWS,
    parameter int COLS  = lianliankan_pkg::COLS,
    parameter int IDX_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_up,
    input  logic                   i_dn,
    input  logic                   i_lt,
    input  logic                   i_rt,
    output logic [IDX_W-1:0]       o_idx,
    output logic [ROWS*COLS-1:0]   o_onehot
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [N-1:0]  ONE_N   = N'(1);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    // Apply at most one move per cycle, wrapping at grid edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (i_up)
                r_row <= (r_row == '0) ? ROW_MAX : r_row - 1'b1;
            else if (i_dn)
                r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
            else if (i_lt)
                r_col <= (r_col == '0) ? COL_MAX : r_col - 1'b1;
            else if (i_rt)
                r_col <= (r_col == COL_MAX) ? '0 : r_col + 1'b1;
        end
    end

    // Linear index = row*COLS + col, then decode to one-hot.
    always_comb begin
        o_idx    = IDX_W'(int'(r_row) * COLS + int'(r_col));
        o_onehot = ONE_N << o_idx;
    end

endmodule

// File: rtl/match_ctrl.sv
// Match game controller: cursor/select handling, pair comparison, and
// per-card match/mismatch strobes with score and game-over tracking.
// Optional MISMATCH_HOLD_EN adds a HOLD phase so a mismatched pair stays
// visible for HOLD_CYCLES before the mismatch strobes go out.
module match_ctrl
    import lianliankan_pkg::*;
#(
    parameter int ROWS        = lianliankan_pkg::ROWS,
    parameter int COLS        = lianliankan_pkg::COLS,
    parameter int FACE_W      = lianliankan_pkg::FACE_W,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_up,
    input  logic                          btn_dn,
    input  logic                          btn_lt,
    input  logic                          btn_rt,
    input  logic                          btn_sel,
    input  logic [ROWS*COLS*FACE_W-1:0]   face_bus,
    input  logic [ROWS*COLS-1:0]          sel_bus,
    input  logic [ROWS*COLS-1:0]          hidden_bus,
    output logic [ROWS*COLS-1:0]          cur_bus,
    output logic                          s,
    output logic                          mf,
    output logic                          ms,
    output logic [4:0]                    score,
    output logic                          game_over
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [4:0]   SCORE_MAX = 5'(N / 2);
    localparam logic [N-1:0] ONE_N     = N'(1);

    state_t            r_state, w_state_nxt;
    result_t           r_result, w_result_nxt;
    logic [IDX_W-1:0]  r_idx_a, r_idx_b;
    logic [IDX_W-1:0]  w_cur_idx;
    logic [N-1:0]      w_cur_oh;
    logic              r_s, r_ms, r_mf, r_go;
    logic [4:0]        r_score;
    logic              w_btn_en, w_elig, w_face_eq, w_res_nxt;

`ifdef MISMATCH_HOLD_EN
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [HCW-1:0] r_hold_cnt;
`else
    logic w_unused_hold;
    assign w_unused_hold = ^HOLD_CYCLES;
`endif

    cursor_nav #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_nav (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_btn_en),
        .i_up     (btn_up),
        .i_dn     (btn_dn),
        .i_lt     (btn_lt),
        .i_rt     (btn_rt),
        .o_idx    (w_cur_idx),
        .o_onehot (w_cur_oh)
    );

    // Buttons count only while picking and before the game has ended.
    always_comb begin
        w_btn_en  = ((r_state == IDLE) || (r_state == ONE)) && !r_go;
        w_elig    = w_btn_en && btn_sel && !hidden_bus[w_cur_idx] && !sel_bus[w_cur_idx];
        w_face_eq = (face_bus[r_idx_a*FACE_W +: FACE_W] == face_bus[r_idx_b*FACE_W +: FACE_W]);
    end

    // Next-state and result decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        case (r_state)
            IDLE:  if (w_elig) w_state_nxt = ONE;
            ONE:   if (w_elig) w_state_nxt = WAIT;
            WAIT:  w_state_nxt = CMP;
            CMP: begin
                if (w_face_eq) begin
                    w_result_nxt = MATCH;
                    w_state_nxt  = RES_A;
                end else begin
                    w_result_nxt = MISMATCH;
`ifdef MISMATCH_HOLD_EN
                    w_state_nxt  = HOLD;
`else
                    w_state_nxt  = RES_A;
`endif
                end
            end
`ifdef MISMATCH_HOLD_EN
            HOLD:  if (r_hold_cnt == '0) w_state_nxt = RES_A;
`endif
            RES_A: w_state_nxt = RES_B;
            RES_B: w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_res_nxt = (w_state_nxt == RES_A) || (w_state_nxt == RES_B);
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= MATCH;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
        end
    end

`ifdef MISMATCH_HOLD_EN
    // Mismatch display delay: load on entry to HOLD, count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_hold_cnt <= '0;
        else if ((r_state == CMP) && (w_state_nxt == HOLD))
            r_hold_cnt <= HCW'(HOLD_CYCLES - 1);
        else if ((r_state == HOLD) && (r_hold_cnt != '0))
            r_hold_cnt <= r_hold_cnt - 1'b1;
    end
`endif

    // Latch the picked card indices; the select uses the pre-move cursor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx_a <= '0;
            r_idx_b <= '0;
        end else if (w_elig) begin
            if (r_state == IDLE) r_idx_a <= w_cur_idx;
            else                 r_idx_b <= w_cur_idx;
        end
    end

    // Registered one-cycle strobes; ms/mf line up with the RES_A/RES_B address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s  <= 1'b0;
            r_ms <= 1'b0;
            r_mf <= 1'b0;
        end else begin
            r_s  <= w_elig;
            r_ms <= w_res_nxt && (w_result_nxt == MATCH);
            r_mf <= w_res_nxt && (w_result_nxt == MISMATCH);
        end
    end

    // Score bumps once per matched pair as the resolution retires; sticky game-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score <= '0;
            r_go    <= 1'b0;
        end else begin
            if ((r_state == DONE) && (r_result == MATCH) && (r_score < SCORE_MAX))
                r_score <= r_score + 1'b1;
            r_go <= r_go | (&hidden_bus);
        end
    end

    // Card address: resolved card during RES_A/RES_B, otherwise the cursor.
    always_comb begin
        case (r_state)
            RES_A:   cur_bus = ONE_N << r_idx_a;
            RES_B:   cur_bus = ONE_N << r_idx_b;
            default: cur_bus = w_cur_oh;
        endcase
        s         = r_s;
        ms        = r_ms;
        mf        = r_mf;
        score     = r_score;
        game_over = r_go;
    end

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed scenarios plus random button
// traffic, all compared against a transaction-timeline model of the game.
module tb_match_ctrl;

    localparam int ROWS = 6;
    localparam int COLS = 6;
    localparam int N    = ROWS * COLS;
    localparam int FW   = 4;
    localparam int H    = 4;
`ifdef MISMATCH_HOLD_EN
    localparam int HOLD_EXTRA = H;
`else
    localparam int HOLD_EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              btn_up, btn_dn, btn_lt, btn_rt, btn_sel;
    logic [N*FW-1:0]   face_bus;
    logic [N-1:0]      sel_bus, hidden_bus;
    logic [N-1:0]      cur_bus;
    logic              s, mf, ms, game_over;
    logic [4:0]        score;

    match_ctrl #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .FACE_W      (FW),
        .HOLD_CYCLES (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .btn_lt     (btn_lt),
        .btn_rt     (btn_rt),
        .btn_sel    (btn_sel),
        .face_bus   (face_bus),
        .sel_bus    (sel_bus),
        .hidden_bus (hidden_bus),
        .cur_bus    (cur_bus),
        .s          (s),
        .mf         (mf),
        .ms         (ms),
        .score      (score),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Reference model: player view of the game plus the card array's flags.
    int  row, col, npick, a_m, b_m, res_cnt, score_m;
    bit  go_m, match_m;
    int  face [N];
    bit  selm [N];
    bit  hid  [N];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_buses();
        for (int i = 0; i < N; i++) begin
            face_bus[i*FW +: FW] = FW'(face[i]);
            sel_bus[i]           = selm[i];
            hidden_bus[i]        = hid[i];
        end
    endtask

    task automatic model_reset();
        row = 0; col = 0; npick = 0; a_m = 0; b_m = 0;
        res_cnt = -1; score_m = 0; go_m = 0; match_m = 0;
        for (int i = 0; i < N; i++) begin
            selm[i] = 0;
            hid[i]  = 0;
        end
    endtask

    // One clock: drive buttons, advance the model over the edge, compare outputs.
    task automatic step(input bit u, input bit d, input bit l, input bit r, input bit sl);
        int c, card, lat;
        bit all_h, es, ems, emf;
        logic [N-1:0] one_v, exp_cur;
        one_v = 1;
        drive_buses();
        btn_up = u; btn_dn = d; btn_lt = l; btn_rt = r; btn_sel = sl;
        @(posedge clk);
        all_h = 1;
        for (int i = 0; i < N; i++) if (!hid[i]) all_h = 0;
        es = 0; ems = 0; emf = 0; card = -1;
        lat = 2 + (match_m ? 0 : HOLD_EXTRA);
        if (res_cnt >= 0) begin
            res_cnt++;
            if (res_cnt == lat || res_cnt == lat + 1) begin
                card = (res_cnt == lat) ? a_m : b_m;
                ems  = match_m;
                emf  = !match_m;
                if (match_m) hid[card] = 1;
                selm[card] = 0;
            end
            if (res_cnt == lat + 3) begin
                if (match_m && score_m < N / 2) score_m++;
                res_cnt = -1;
                npick   = 0;
            end
        end else if (!go_m) begin
            c = row * COLS + col;
            if (sl && !hid[c] && !selm[c]) begin
                es = 1;
                selm[c] = 1;
                if (npick == 0) begin
                    a_m = c; npick = 1;
                end else begin
                    b_m = c; match_m = (face[a_m] == face[b_m]); res_cnt = 0;
                end
            end
            if (u)      row = (row + ROWS - 1) % ROWS;
            else if (d) row = (row + 1) % ROWS;
            else if (l) col = (col + COLS - 1) % COLS;
            else if (r) col = (col + 1) % COLS;
        end
        go_m = go_m | all_h;
        exp_cur = (card >= 0) ? (one_v << card) : (one_v << (row * COLS + col));
        #1;
        chk("cur_bus", cur_bus, exp_cur);
        chk("s", s, es);
        chk("ms", ms, ems);
        chk("mf", mf, emf);
        chk("score", score, score_m);
        chk("game_over", game_over, go_m);
        btn_up = 0; btn_dn = 0; btn_lt = 0; btn_rt = 0; btn_sel = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_cur_bus", cur_bus, 1);
        chk("rst_s", s, 0);
        chk("rst_ms", ms, 0);
        chk("rst_mf", mf, 0);
        chk("rst_score", score, 0);
        chk("rst_game_over", game_over, 0);
        model_reset();
        drive_buses();
        @(posedge clk);
        #1;
        chk("rst_hold_cur_bus", cur_bus, 1);
        chk("rst_hold_ms", ms, 0);
        chk("rst_hold_mf", mf, 0);
        rst = 0;
    endtask

    initial begin
        logic [N-1:0] one_v;
        one_v = 1;
        btn_up = 0; btn_dn = 0; btn_lt = 0; btn_rt = 0; btn_sel = 0;
        for (int i = 0; i < N; i++) face[i] = 8 + int'($urandom_range(0, 3));
        face[3] = 7; face[17] = 7;
        face[0] = 2; face[1]  = 5;
        model_reset();
        drive_buses();
        do_reset();

        // Cursor wrap on both axes.
        step(0, 0, 1, 0, 0);
        chk("wrap_left", cur_bus, one_v << 5);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("wrap_up", cur_bus, one_v << 30);
        step(0, 1, 0, 0, 0);
        chk("wrap_down", cur_bus, one_v);

        // Matching pair 3 / 17.
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        idle(6);
        chk("match_score", score, 1);
        chk("match_cursor_back", cur_bus, one_v << 17);

        // Mismatching pair 0 / 1, with select+move in one cycle on card 0.
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        idle(6 + HOLD_EXTRA);
        chk("mismatch_score", score, 1);

        // Ineligible selects: same card twice, then a hidden card.
        step(0, 1, 0, 0, 0); step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reselect_no_s", s, 0);
        hid[9] = 1;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("hidden_no_s", s, 0);
        hid[9] = 0;
        step(0, 0, 0, 0, 1);
        idle(8 + HOLD_EXTRA);

        // Random button traffic.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0);

        // Reset while the first resolution strobe is on the bus.
        do_reset();
        face[0] = 9; face[1] = 9; face[2] = 9; face[3] = 9;
        step(0, 0, 0, 0, 1); step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 1);
        idle(6);
        chk("pre_reset_score", score, 1);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 1);
        idle(2);
        chk("res_a_strobe", ms, 1);
        chk("res_a_addr", cur_bus, one_v << 2);
        do_reset();
        idle(3);

        // All cards removed: game over, buttons ignored.
        for (int i = 0; i < N; i++) hid[i] = 1;
        step(0, 0, 0, 0, 0);
        chk("game_over_set", game_over, 1);
        step(0, 0, 0, 0, 1);
        chk("game_over_no_s", s, 0);
        step(0, 0, 0, 1, 0);
        chk("game_over_no_move", cur_bus, one_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Game controller on the driving side of the card array's control interface.
- Turns player button pulses into cursor movement (`cur_bus`) and select strobes (`s`).
- Tracks the two cards the player has picked, compares their face IDs, and resolves the pair by issuing `ms` (match) or `mf` (mismatch) to each card in turn.
- Keeps the matched-pair score and flags game completion.

Parameters:
- ROWS, 6, grid rows.
- COLS, 6, grid columns. N = ROWS*COLS = 36.
- FACE_W, 4, bits per card face ID.
- HOLD_CYCLES, 25_000_000, mismatch display delay in clk cycles. Used only with MISMATCH_HOLD_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  async reset, active-high.
- btn_up, btn_dn, btn_lt, btn_rt  in  1 each  one-cycle debounced move pulses.
- btn_sel  in  1  one-cycle debounced select pulse.
- face_bus  in  N*FACE_W  face ID of card i at bits [i*FACE_W +: FACE_W].
- sel_bus  in  N  per-card selected flags from the card array.
- hidden_bus  in  N  per-card removed flags from the card array.
- cur_bus  out  N  one-hot card address. The array applies `mf`/`ms` only to the addressed card.
- s  out  1  select strobe to the addressed card.
- mf  out  1  mismatch strobe.
- ms  out  1  match strobe.
- score  out  5  matched pairs, 0..N/2.
- game_over  out  1  all cards hidden.

Behaviour:
- Reset values:
  - cursor index 0, so `cur_bus` = 36'h1.
  - s, mf, ms, score, game_over all 0.
  - FSM in IDLE.
- Cursor:
  - Index = row*COLS + col.
  - Move pulses update the index next cycle, with wrap on each axis:
    - up from row 0 goes to row ROWS-1;
    - right from col COLS-1 goes to col 0.
  - Simultaneous move pulses: priority up > dn > lt > rt, one move per cycle.
  - Moves are ignored outside IDLE/ONE.
- Selection is eligible only when the cursor card has hidden=0 and sel=0.
  - Eligible `btn_sel` raises `s` for exactly one cycle and latches the cursor index into idx_a (from IDLE) or idx_b (from ONE).
  - Ineligible `btn_sel` is dropped silently.
  - A simultaneous move and select in the same cycle: the select uses the pre-move index; the move still applies.
- FSM states:
  - IDLE: eligible sel -> ONE.
  - ONE: eligible sel -> WAIT.
  - WAIT: one cycle so `sel_bus` can settle -> CMP.
  - CMP: compare face[idx_a] vs face[idx_b].
    - Equal -> RES_A with result=match.
    - Unequal -> HOLD (if MISMATCH_HOLD_EN) or RES_A with result=mismatch.
  - HOLD: count HOLD_CYCLES-1 down to 0, then -> RES_A.
  - RES_A: `cur_bus` = onehot(idx_a); assert ms or mf (per result) for one cycle -> RES_B.
  - RES_B: same for idx_b -> DONE.
  - DONE: restore `cur_bus` = onehot(cursor).
    - On match, score += 1, saturating at N/2.
    - -> IDLE.
- Output timing:
  - All strobes are registered one-cycle pulses.
  - `mf` and `ms` are never high together.
  - `s` is never high in RES_A/RES_B.
  - From second eligible sel to the RES_A strobe: 3 cycles without hold, 3+HOLD_CYCLES with hold.
- The cursor register is untouched during RES_A/RES_B; only the `cur_bus` mux changes.
- game_over:
  - Registered `&hidden_bus`.
  - Once set, all buttons are ignored until reset.
  - The FSM finishes any in-flight resolution before honouring it.
- Reset mid-resolution: everything returns to reset values immediately; no strobe completes.

Optional Feature:
- Macro MISMATCH_HOLD_EN.
- Defined: HOLD state present; both mismatched cards stay selected/visible for HOLD_CYCLES before `mf` strobes.
- Undefined: no HOLD state and no hold counter logic; CMP goes directly to RES_A. HOLD_CYCLES is unused.

Decomposition:
- Shared package lianliankan_pkg holds:
  - ROWS, COLS, N, FACE_W constants;
  - FSM state enum (IDLE, ONE, WAIT, CMP, HOLD, RES_A, RES_B, DONE);
  - result enum (MATCH, MISMATCH).
- Sub-module cursor_nav holds the cursor index register, wrap arithmetic, move priority, and index-to-one-hot decode. Its inputs are moves plus an enable from the FSM.

Test Plan:
- Reset, then 1 btn_lt -> cursor index 5, `cur_bus` = 36'h20; 1 btn_up from index 0 -> index 30.
- face[3]=face[17]=7; select 3 then 17 -> s pulses twice; ms one cycle with `cur_bus`=bit3, then one cycle with bit17; score=1; `cur_bus` returns to bit17 (cursor).
- face[0]=2, face[1]=5; select 0 then 1 with hold off -> mf at bit0 then bit1, no ms, score unchanged. With MISMATCH_HOLD_EN and HOLD_CYCLES=4 -> first mf exactly 4 cycles later.
- Select card 8 twice, or a card with hidden=1 -> no `s` on the ineligible press; FSM state unchanged.
- hidden_bus all ones -> game_over=1 next cycle; subsequent btn_sel and moves produce no `s` and no cursor change.
- Assert rst during RES_A -> no RES_B strobe; outputs return to reset values; score=0.
